// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory between instruction fetch and load/store.
// One access at a time: IDLE grant -> ACCESS for MEM_LAT cycles -> RESP one-cycle ack.
module mem_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   output logic [63:0]       d_rdata,
   output logic              d_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic              mem_wr,
   input  logic [63:0]       mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              sel_hi_q, sel_hi_d;
   logic [2:0]        lat_q, lat_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [63:0]       mem_wdata_q, mem_wdata_d;
   logic              mem_wr_q, mem_wr_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [63:0]       d_rdata_q, d_rdata_d;
   logic              grant_data_s;
   logic              if_addr_unused_s;

   // Fetch addresses are word-aligned; only bit 2 selects the instruction half.
   assign if_addr_unused_s = ^if_addr[1:0];

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      sel_hi_d     = sel_hi_q;
      lat_d        = lat_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wr_d     = 1'b0;
      if_ack_d     = 1'b0;
      d_ack_d      = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      grant_data_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               // On a tie the port opposite to the last owner wins.
               grant_data_s = d_req && (!if_req || !owner_q);
               owner_d      = grant_data_s;
               we_d         = grant_data_s && d_we;
               mem_wr_d     = grant_data_s && d_we;
               lat_d        = 3'(MEM_LAT - 1);
               state_d      = ACCESS;
               if (grant_data_s) begin
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  sel_hi_d    = 1'b0;
               end else begin
                  mem_addr_d  = {if_addr[ADDR_W-1:3], 3'b000};
                  mem_wdata_d = mem_wdata_q;
                  sel_hi_d    = if_addr[2];
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (lat_q == 3'd0) begin
               state_d = RESP;
               if (owner_q) begin
                  d_ack_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = d_rdata_q;
                  end
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
               end
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b1;
         we_q        <= 1'b0;
         sel_hi_q    <= 1'b0;
         lat_q       <= 3'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 64'd0;
         mem_wr_q    <= 1'b0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         if_rdata_q  <= 32'd0;
         d_rdata_q   <= 64'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         sel_hi_q    <= sel_hi_d;
         lat_q       <= lat_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wr    = mem_wr_q;
   assign busy      = (state_q != IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 backed by a small memory,
// one with MEM_LAT=3 whose read data is driven cycle by cycle.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst3;
   int          n_cmp = 0;
   int          n_err = 0;

   logic        a_if_req, a_if_ack, a_d_req, a_d_we, a_d_ack, a_mem_wr, a_busy, a_owner;
   logic [63:0] a_if_addr, a_d_addr, a_d_wdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [31:0] a_if_rdata;

   logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_wr, b_busy, b_owner;
   logic [63:0] b_if_addr, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [31:0] b_if_rdata;

   logic [63:0] mem1 [0:15];

   mem_arbiter #(.ADDR_W(64), .MEM_LAT(1)) u1 (
      .clk(clk), .reset(rst1),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_rdata(a_d_rdata), .d_ack(a_d_ack),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wr(a_mem_wr), .mem_rdata(a_mem_rdata),
      .busy(a_busy), .owner(a_owner)
   );

   mem_arbiter #(.ADDR_W(64), .MEM_LAT(3)) u3 (
      .clk(clk), .reset(rst3),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_rdata(b_d_rdata), .d_ack(b_d_ack),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wr(b_mem_wr), .mem_rdata(b_mem_rdata),
      .busy(b_busy), .owner(b_owner)
   );

   // Zero-latency-read memory for the MEM_LAT=1 instance; writes land on the strobe edge.
   always @(posedge clk) begin
      if (a_mem_wr) mem1[a_mem_addr[6:3]] <= a_mem_wdata;
   end
   assign a_mem_rdata = mem1[a_mem_addr[6:3]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic data_txn1(input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] exp_rdata);
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
      tick();
      chk1("d1 busy at grant", a_busy, 1'b1);
      chk1("d1 owner at grant", a_owner, 1'b1);
      chk("d1 mem_addr", a_mem_addr, addr);
      chk("d1 mem_wdata", a_mem_wdata, wdata);
      chk1("d1 mem_wr first access cycle", a_mem_wr, we);
      chk1("d1 early d_ack", a_d_ack, 1'b0);
      tick();
      chk1("d1 d_ack", a_d_ack, 1'b1);
      chk1("d1 if_ack quiet", a_if_ack, 1'b0);
      chk1("d1 mem_wr dropped", a_mem_wr, 1'b0);
      chk("d1 d_rdata", a_d_rdata, exp_rdata);
      a_d_req = 1'b0;
      tick();
      chk1("d1 d_ack single", a_d_ack, 1'b0);
      chk1("d1 idle", a_busy, 1'b0);
   endtask

   task automatic fetch_txn1(input logic [63:0] addr, input logic [63:0] exp_maddr,
                             input logic [31:0] exp_word);
      a_if_req = 1'b1; a_if_addr = addr;
      tick();
      chk1("f1 busy at grant", a_busy, 1'b1);
      chk1("f1 owner at grant", a_owner, 1'b0);
      chk("f1 mem_addr", a_mem_addr, exp_maddr);
      chk1("f1 no mem_wr", a_mem_wr, 1'b0);
      chk1("f1 early if_ack", a_if_ack, 1'b0);
      tick();
      chk1("f1 if_ack", a_if_ack, 1'b1);
      chk1("f1 d_ack quiet", a_d_ack, 1'b0);
      chk("f1 if_rdata", {32'd0, a_if_rdata}, {32'd0, exp_word});
      a_if_req = 1'b0;
      tick();
      chk1("f1 if_ack single", a_if_ack, 1'b0);
      chk1("f1 idle", a_busy, 1'b0);
   endtask

   initial begin
      rst1 = 1'b1; rst3 = 1'b1;
      a_if_req = 1'b0; a_if_addr = 64'd0; a_d_req = 1'b0; a_d_we = 1'b0;
      a_d_addr = 64'd0; a_d_wdata = 64'd0;
      b_if_req = 1'b0; b_if_addr = 64'd0; b_d_req = 1'b0; b_d_we = 1'b0;
      b_d_addr = 64'd0; b_d_wdata = 64'd0; b_mem_rdata = 64'd0;
      tick();
      tick();
      chk1("rst busy", a_busy, 1'b0);
      chk1("rst owner", a_owner, 1'b1);
      chk1("rst if_ack", a_if_ack, 1'b0);
      chk1("rst d_ack", a_d_ack, 1'b0);
      chk1("rst mem_wr", a_mem_wr, 1'b0);
      chk("rst if_rdata", {32'd0, a_if_rdata}, 64'd0);
      chk("rst d_rdata", a_d_rdata, 64'd0);
      chk("rst mem_addr", a_mem_addr, 64'd0);
      chk("rst mem_wdata", a_mem_wdata, 64'd0);
      chk1("rst3 owner", b_owner, 1'b1);
      rst1 = 1'b0; rst3 = 1'b0;
      tick();

      // Stores, load, then fetches of both halves of the word at 0x10.
      data_txn1(1'b1, 64'h10, 64'hAAAA_BBBB_1111_2222, 64'd0);
      data_txn1(1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, 64'd0);
      data_txn1(1'b0, 64'h40, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF);
      fetch_txn1(64'h14, 64'h10, 32'hAAAA_BBBB);
      fetch_txn1(64'h10, 64'h10, 32'h1111_2222);

      // Both ports held from reset: fetch, data, fetch, data, acks 3 cycles apart.
      rst1 = 1'b1;
      tick();
      chk1("tie rst owner", a_owner, 1'b1);
      rst1 = 1'b0;
      a_if_addr = 64'h10; a_d_we = 1'b0; a_d_addr = 64'h40;
      a_if_req = 1'b1; a_d_req = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         chk1("tie if_ack", a_if_ack, (i % 6) == 1);
         chk1("tie d_ack", a_d_ack, (i % 6) == 4);
         chk1("tie owner", a_owner, ((i / 3) % 2) == 1);
         chk1("tie busy", a_busy, (i % 3) != 2);
         if (i == 1) chk("tie if_rdata", {32'd0, a_if_rdata}, 64'h1111_2222);
         if (i == 4) chk("tie d_rdata", a_d_rdata, 64'h0123_4567_89AB_CDEF);
      end
      a_if_req = 1'b0; a_d_req = 1'b0;
      tick();
      chk1("tie idle", a_busy, 1'b0);

      // d_req held past its ack; if_req arrives during RESP and wins the next grant.
      a_if_addr = 64'h14; a_d_req = 1'b1;
      for (int i = 0; i <= 9; i++) begin
         tick();
         chk1("hold d_ack", a_d_ack, (i == 1) || (i == 7));
         chk1("hold if_ack", a_if_ack, i == 4);
         chk1("hold owner", a_owner, (i <= 2) || (i >= 6));
         chk1("hold busy", a_busy, !((i == 2) || (i == 5) || (i >= 8)));
         if (i == 4) chk("hold if_rdata", {32'd0, a_if_rdata}, 64'hAAAA_BBBB);
         if (i == 1) a_if_req = 1'b1;
         if (i == 4) a_if_req = 1'b0;
         if (i == 7) a_d_req = 1'b0;
      end

      // MEM_LAT=3 load: only the value present before the third ACCESS edge is captured.
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 64'h80; b_mem_rdata = 64'hDEAD_DEAD_DEAD_0001;
      tick();
      chk1("lat3 busy", b_busy, 1'b1);
      chk("lat3 mem_addr", b_mem_addr, 64'h80);
      chk1("lat3 ack e0", b_d_ack, 1'b0);
      b_mem_rdata = 64'hDEAD_DEAD_DEAD_0002;
      tick();
      chk1("lat3 ack e1", b_d_ack, 1'b0);
      b_mem_rdata = 64'h1122_3344_5566_7788;
      tick();
      chk1("lat3 ack e2", b_d_ack, 1'b0);
      tick();
      chk1("lat3 ack e3", b_d_ack, 1'b1);
      chk("lat3 d_rdata", b_d_rdata, 64'h1122_3344_5566_7788);
      b_mem_rdata = 64'hDEAD_DEAD_DEAD_0003;
      b_d_req = 1'b0;
      tick();
      chk1("lat3 ack single", b_d_ack, 1'b0);
      chk("lat3 d_rdata held", b_d_rdata, 64'h1122_3344_5566_7788);

      // Reset during ACCESS of a store: outputs clear before the next edge, no ack ever.
      b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 64'h88; b_d_wdata = 64'hCAFE_F00D_0000_1234;
      tick();
      chk1("rsta mem_wr", b_mem_wr, 1'b1);
      chk1("rsta busy", b_busy, 1'b1);
      tick();
      chk1("rsta mem_wr once", b_mem_wr, 1'b0);
      chk1("rsta busy mid", b_busy, 1'b1);
      rst3 = 1'b1; b_d_req = 1'b0;
      #1;
      chk1("rsta async busy", b_busy, 1'b0);
      chk1("rsta async mem_wr", b_mem_wr, 1'b0);
      chk1("rsta async d_ack", b_d_ack, 1'b0);
      chk1("rsta async if_ack", b_if_ack, 1'b0);
      chk("rsta async d_rdata", b_d_rdata, 64'd0);
      chk("rsta async mem_addr", b_mem_addr, 64'd0);
      tick();
      rst3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("rsta no ack", b_d_ack, 1'b0);
         chk1("rsta stays idle", b_busy, 1'b0);
      end
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 64'h90; b_mem_rdata = 64'h5555_AAAA_0F0F_F0F0;
      for (int i = 0; i <= 3; i++) begin
         tick();
         chk1("reissue d_ack", b_d_ack, i == 3);
         chk1("reissue busy", b_busy, 1'b1);
         chk1("reissue owner", b_owner, 1'b1);
      end
      chk("reissue d_rdata", b_d_rdata, 64'h5555_AAAA_0F0F_F0F0);
      b_d_req = 1'b0;
      tick();
      chk1("reissue ack single", b_d_ack, 1'b0);
      chk1("reissue idle", b_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
